shift_out: RTL



---
 rtl/shift_out.sv | 93 +++++++++
 1 files changed

// File: rtl/shift_out.sv
// Parallel-to-serial transmitter: loads a WIDTH-bit word on start and shifts it
// out MSB first, one bit per ena strobe, with registered frame/busy/done flags.
module shift_out #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ena,
  output logic             data_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             data_out_q;
  logic             frame_q;
  logic             busy_q;
  logic             done_q;

  // Transmit FSM: load on start in IDLE, consume one bit per ena edge in SHIFT.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      frame_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q       <= data_in;
            data_out_q <= data_in[WIDTH-1];
            cnt_q      <= CW'(WIDTH);
            frame_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end else begin
            data_out_q <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        SHIFT: begin
          // The receiver samples data_out on this same ena edge, so advancing now is safe.
          if (ena) begin
            if (cnt_q > CW'(1)) begin
              sr_q       <= {sr_q[WIDTH-2:0], 1'b0};
              data_out_q <= sr_q[WIDTH-2];
              cnt_q      <= cnt_q - CW'(1);
            end else begin
              sr_q       <= '0;
              cnt_q      <= '0;
              data_out_q <= 1'b0;
              frame_q    <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end
          end else begin
            state_q <= SHIFT;
          end
        end
        default: begin
          state_q    <= IDLE;
          sr_q       <= '0;
          cnt_q      <= '0;
          data_out_q <= 1'b0;
          frame_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = data_out_q;
  assign frame    = frame_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
